// File: rtl/mips_checkpoint_monitor.sv
// Self-check engine: samples N_CHK observed buses at programmed cycle offsets
// after a start pulse and compares them to masked expected values.

module mips_chk_lane #(
   parameter int DW = 32
) (
   input  logic [DW-1:0] obs,
   input  logic [DW-1:0] exp_v,
   input  logic [DW-1:0] mask,
   output logic          match
);
   assign match = ~|((obs ^ exp_v) & mask);
endmodule

module mips_checkpoint_monitor #(
   parameter  int N_CHK        = 4,
   parameter  int DW           = 32,
   parameter  int CW           = 16,
   parameter  int STOP_ON_FAIL = 0,
   localparam int IW           = $clog2(N_CHK + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [N_CHK*CW-1:0] chk_cycle,
   input  logic [N_CHK*DW-1:0] obs_val,
   input  logic [N_CHK*DW-1:0] exp_val,
   input  logic [N_CHK*DW-1:0] chk_mask,
   output logic                busy,
   output logic                done,
   output logic                all_pass,
   output logic [N_CHK-1:0]    pass_flag,
   output logic [N_CHK-1:0]    fail_flag,
   output logic [IW-1:0]       chk_idx,
   output logic [CW-1:0]       cycle_cnt
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t state, state_nx;

   logic [N_CHK-1:0][CW-1:0] cyc_a;
   logic [N_CHK-1:0][DW-1:0] obs_a, exp_a, msk_a;
   logic [N_CHK-1:0]         match, sel;
   logic [CW-1:0]            cur_cyc;
   logic                     cur_match, fire, last, stop;

   assign cyc_a = chk_cycle;
   assign obs_a = obs_val;
   assign exp_a = exp_val;
   assign msk_a = chk_mask;

   genvar g;
   generate
      for (g = 0; g < N_CHK; g++) begin : g_lane
         mips_chk_lane #(.DW(DW)) u_lane (
            .obs   (obs_a[g]),
            .exp_v (exp_a[g]),
            .mask  (msk_a[g]),
            .match (match[g])
         );
      end
   endgenerate

   // Only the checkpoint addressed by chk_idx is live on any given cycle.
   always_comb begin
      sel       = '0;
      cur_cyc   = '0;
      cur_match = 1'b0;
      for (int i = 0; i < N_CHK; i++) begin
         if (chk_idx == IW'(i)) begin
            sel[i]    = 1'b1;
            cur_cyc   = cyc_a[i];
            cur_match = match[i];
         end
      end
   end

   assign fire = (state == RUN) && (cycle_cnt >= cur_cyc);
   assign last = (chk_idx == IW'(N_CHK - 1));
   assign stop = fire && (last || ((STOP_ON_FAIL != 0) && !cur_match));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: if (start) state_nx = RUN;
         RUN: begin
            busy = 1'b1;
            if (!start && stop) state_nx = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) state_nx = RUN;
         end
         default: state_nx = IDLE;
      endcase
   end

   // A start pulse always wins, so a restart mid-run discards partial results.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cycle_cnt <= '0;
         chk_idx   <= '0;
         pass_flag <= '0;
         fail_flag <= '0;
         all_pass  <= 1'b0;
      end else if (start) begin
         cycle_cnt <= '0;
         chk_idx   <= '0;
         pass_flag <= '0;
         fail_flag <= '0;
         all_pass  <= 1'b0;
      end else if (state == RUN) begin
         if (cycle_cnt != {CW{1'b1}}) cycle_cnt <= cycle_cnt + CW'(1);
         if (fire) begin
            chk_idx <= chk_idx + IW'(1);
            if (cur_match) pass_flag <= pass_flag | sel;
            else           fail_flag <= fail_flag | sel;
            if (stop) all_pass <= cur_match && (&(pass_flag | sel));
         end
      end
   end
endmodule

// File: tb/tb_mips_checkpoint_monitor.sv
// Bench for mips_checkpoint_monitor: directed table, hand-written corner
// sequences and randomized runs against an edge-schedule reference model.

module tb_mips_checkpoint_monitor;
   localparam int N  = 4;
   localparam int DW = 32;
   localparam int CW = 16;
   localparam logic [N-1:0][DW-1:0] V  = {32'h0000_0444, 32'h0000_447a, 32'h0000_2222, 32'h0000_1111};
   localparam logic [N-1:0][DW-1:0] V2 = {32'h0000_0444, 32'h0000_447b, 32'h0000_2222, 32'h0000_1111};
   localparam logic [N-1:0][DW-1:0] VF = {32'h0000_0444, 32'h0000_447a, 32'h0000_2222, 32'h0000_1110};
   localparam logic [N-1:0][DW-1:0] VO = {32'h0000_0444, 32'h0000_447a, 32'h0000_2222, 32'h1234_56ab};
   localparam logic [N-1:0][DW-1:0] VE = {32'h0000_0444, 32'h0000_447a, 32'h0000_2222, 32'h0000_00ab};
   localparam logic [N-1:0][DW-1:0] MO = {{3{32'hffff_ffff}}, 32'h0000_00ff};
   localparam logic [N-1:0][DW-1:0] M1 = {N{32'hffff_ffff}};

   logic clk = 1'b0, reset = 1'b0, start = 1'b0;
   logic [N-1:0][CW-1:0] off;
   logic [N-1:0][3:0]    off_s;
   logic [N-1:0][DW-1:0] obs, expv, mask;

   logic busy0, done0, ap0, busy1, done1, ap1, busy2, done2, ap2;
   logic [N-1:0] pf0, ff0, pf1, ff1, pf2, ff2;
   logic [2:0]   ix0, ix1, ix2;
   logic [CW-1:0] cc0, cc1;
   logic [3:0]   cc2;

   mips_checkpoint_monitor #(.N_CHK(N), .DW(DW), .CW(CW), .STOP_ON_FAIL(0)) dut0 (
      .clk(clk), .reset(reset), .start(start), .chk_cycle(off), .obs_val(obs),
      .exp_val(expv), .chk_mask(mask), .busy(busy0), .done(done0), .all_pass(ap0),
      .pass_flag(pf0), .fail_flag(ff0), .chk_idx(ix0), .cycle_cnt(cc0));

   mips_checkpoint_monitor #(.N_CHK(N), .DW(DW), .CW(CW), .STOP_ON_FAIL(1)) dut1 (
      .clk(clk), .reset(reset), .start(start), .chk_cycle(off), .obs_val(obs),
      .exp_val(expv), .chk_mask(mask), .busy(busy1), .done(done1), .all_pass(ap1),
      .pass_flag(pf1), .fail_flag(ff1), .chk_idx(ix1), .cycle_cnt(cc1));

   mips_checkpoint_monitor #(.N_CHK(N), .DW(DW), .CW(4), .STOP_ON_FAIL(0)) dut2 (
      .clk(clk), .reset(reset), .start(start), .chk_cycle(off_s), .obs_val(obs),
      .exp_val(expv), .chk_mask(mask), .busy(busy2), .done(done2), .all_pass(ap2),
      .pass_flag(pf2), .fail_flag(ff2), .chk_idx(ix2), .cycle_cnt(cc2));

   always #5 clk = ~clk;

   int checks = 0, failures = 0;
   int ev[N];
   bit pm[N];

   typedef struct {
      logic [N-1:0][CW-1:0] off;
      logic [N-1:0][DW-1:0] obs, ex, mk;
      logic [N-1:0]         p0, f0;
      int                   d0;
      logic [N-1:0]         p1, f1;
      int                   d1;
      logic [2:0]           ix1;
   } vec_t;
   vec_t tbl[5];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int k, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s k=%0d got=%h exp=%h", nm, k, got, exp);
      end
   endtask

   function automatic logic [63:0] pk(logic b, logic d, logic a, logic [N-1:0] p,
                                      logic [N-1:0] f, logic [2:0] ix, logic [15:0] c);
      return 64'({b, d, a, p, f, ix, c});
   endfunction

   // Each checkpoint evaluates one edge after its offset, but never before
   // the edge following its predecessor.
   task automatic build_model;
      for (int i = 0; i < N; i++) begin
         pm[i] = ((obs[i] ^ expv[i]) & mask[i]) == '0;
         ev[i] = int'(off[i]) + 1;
         if (i > 0 && ev[i] <= ev[i-1]) ev[i] = ev[i-1] + 1;
      end
   endtask

   function automatic logic [63:0] model_at(int k, bit sm);
      int last = N - 1;
      int d, n = 0;
      bit allp = 1'b1;
      logic [N-1:0] p = '0, f = '0;
      for (int i = 0; i < N; i++) allp &= pm[i];
      if (sm) for (int i = N - 1; i >= 0; i--) if (!pm[i]) last = i;
      d = ev[last];
      for (int i = 0; i <= last; i++) begin
         if (ev[i] <= k) begin
            if (pm[i]) p[i] = 1'b1;
            else       f[i] = 1'b1;
            n++;
         end
      end
      return pk(k < d, k >= d, (k >= d) && allp, p, f, 3'(n), 16'(k < d ? k : d));
   endfunction

   task automatic do_run(input string nm, output int ds0, output int ds1);
      int d;
      build_model();
      d   = ev[N-1];
      ds0 = -1;
      ds1 = -1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k <= d + 2; k++) begin
         if (k > 0) tick();
         chk({nm, "_nostop"}, k, pk(busy0, done0, ap0, pf0, ff0, ix0, cc0), model_at(k, 1'b0));
         chk({nm, "_stop"},   k, pk(busy1, done1, ap1, pf1, ff1, ix1, cc1), model_at(k, 1'b1));
         if (done0 && ds0 < 0) ds0 = k;
         if (done1 && ds1 < 0) ds1 = k;
      end
   endtask

   initial begin
      int ds0, ds1, b;
      tbl[0] = '{{16'd68, 16'd32, 16'd21, 16'd13}, V,  V,  M1, 4'b1111, 4'b0000, 69, 4'b1111, 4'b0000, 69, 3'd4};
      tbl[1] = '{{16'd68, 16'd32, 16'd21, 16'd13}, V2, V,  M1, 4'b1011, 4'b0100, 69, 4'b0011, 4'b0100, 33, 3'd3};
      tbl[2] = '{{16'd2,  16'd5,  16'd5,  16'd5},  V,  V,  M1, 4'b1111, 4'b0000, 9,  4'b1111, 4'b0000, 9,  3'd4};
      tbl[3] = '{{16'd7,  16'd6,  16'd4,  16'd3},  VO, VE, MO, 4'b1111, 4'b0000, 8,  4'b1111, 4'b0000, 8,  3'd4};
      tbl[4] = '{{16'd0,  16'd0,  16'd0,  16'd0},  VF, V,  M1, 4'b1110, 4'b0001, 4,  4'b0000, 4'b0001, 1,  3'd1};

      off = '0; off_s = '0; obs = V; expv = V; mask = M1;
      tick();
      chk("reset0", 0, pk(busy0, done0, ap0, pf0, ff0, ix0, cc0), 64'd0);
      chk("reset1", 0, pk(busy1, done1, ap1, pf1, ff1, ix1, cc1), 64'd0);
      reset = 1'b1;
      tick();

      for (int t = 0; t < 5; t++) begin
         off = tbl[t].off; obs = tbl[t].obs; expv = tbl[t].ex; mask = tbl[t].mk;
         do_run($sformatf("tbl%0d", t), ds0, ds1);
         chk($sformatf("tbl%0d_res0", t), t, 64'({pf0, ff0, ap0, ds0[15:0]}),
             64'({tbl[t].p0, tbl[t].f0, tbl[t].p0 == 4'b1111, 16'(tbl[t].d0)}));
         chk($sformatf("tbl%0d_res1", t), t, 64'({pf1, ff1, ix1, ds1[15:0]}),
             64'({tbl[t].p1, tbl[t].f1, tbl[t].ix1, 16'(tbl[t].d1)}));
      end

      // Asynchronous reset mid-run, then a fresh run from zero.
      off = tbl[0].off; obs = V; expv = V; mask = M1;
      start = 1'b1; tick(); start = 1'b0;
      for (int k = 1; k <= 20; k++) tick();
      reset = 1'b0;
      #1;
      chk("midreset0", 20, pk(busy0, done0, ap0, pf0, ff0, ix0, cc0), 64'd0);
      chk("midreset1", 20, pk(busy1, done1, ap1, pf1, ff1, ix1, cc1), 64'd0);
      tick(); tick();
      reset = 1'b1;
      tick();
      chk("postreset", 0, pk(busy0, done0, ap0, pf0, ff0, ix0, cc0), 64'd0);
      do_run("after_reset", ds0, ds1);

      // Restart while running: partial flags discarded, offsets relative to new start.
      off = {16'd40, 16'd30, 16'd4, 16'd2};
      start = 1'b1; tick(); start = 1'b0;
      for (int k = 1; k <= 10; k++) tick();
      chk("restart_pre", 10, 64'({busy0, pf0, ix0}), 64'({1'b1, 4'b0011, 3'd2}));
      do_run("restart", ds0, ds1);

      // Saturating counter on a 4-bit instance: all offsets at the maximum.
      off = {N{16'd15}}; off_s = {N{4'd15}};
      start = 1'b1; tick(); start = 1'b0;
      for (int k = 1; k <= 19; k++) begin
         tick();
         if (k == 16) chk("sat16", k, 64'({busy2, pf2, cc2}), 64'({1'b1, 4'b0001, 4'd15}));
         if (k == 18) chk("sat18", k, 64'({done2, pf2}), 64'({1'b0, 4'b0111}));
      end
      chk("sat19", 19, 64'({busy2, done2, ap2, pf2, ff2, ix2, cc2}),
          64'({1'b0, 1'b1, 1'b1, 4'b1111, 4'b0000, 3'd4, 4'd15}));

      // Randomized runs against the reference model.
      for (int r = 0; r < 25; r++) begin
         for (int i = 0; i < N; i++) begin
            off[i]  = CW'($urandom_range(0, 25));
            expv[i] = $urandom;
            mask[i] = ($urandom_range(0, 3) == 0) ? 32'hffff_ffff : 32'($urandom);
            if ($urandom_range(0, 3) != 0) begin
               obs[i] = expv[i] ^ (32'($urandom) & ~mask[i]);
            end else begin
               b = $urandom_range(0, DW - 1);
               mask[i][b] = 1'b1;
               obs[i] = expv[i] ^ (32'd1 << b) ^ (32'($urandom) & ~mask[i]);
            end
         end
         do_run($sformatf("rand%0d", r), ds0, ds1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
